// File: rtl/rx_trena_mensagem_pkg.sv
// Shared constants for the trena link receiver: ASCII framing characters,
// error cause codes and the state encodings of the rx and parser FSMs.
package rx_trena_mensagem_pkg;

    localparam logic [6:0] ASCII_0       = 7'h30;
    localparam logic [6:0] ASCII_9       = 7'h39;
    localparam logic [6:0] ASCII_VIRGULA = 7'h2C;
    localparam logic [6:0] ASCII_FIM     = 7'h23;

    localparam logic [1:0] ERR_NENHUM    = 2'b00;
    localparam logic [1:0] ERR_PARIDADE  = 2'b01;
    localparam logic [1:0] ERR_CARACTERE = 2'b10;
    localparam logic [1:0] ERR_PARADA    = 2'b11;

    typedef enum logic [2:0] {
        REPOUSO,
        INICIO,
        DADOS,
        PARIDADE,
        PARADA
    } rx_estado_t;

    // ESPERA_A2..ESPERA_FIM are consecutive so the parser can step by +1.
    typedef enum logic [3:0] {
        ESPERA_A2,
        ESPERA_A1,
        ESPERA_A0,
        ESPERA_VIRG,
        ESPERA_D2,
        ESPERA_D1,
        ESPERA_D0,
        ESPERA_FIM,
        DESCARTE
    } parser_estado_t;

    function automatic logic eh_digito(input logic [6:0] c);
        return (c >= ASCII_0) && (c <= ASCII_9);
    endfunction

endpackage

// File: rtl/rx_trena_mensagem_rx_serial.sv
// 7O1 asynchronous character receiver: two-flop input synchroniser,
// bit-period counter and rx FSM. Emits one char_pronto pulse per frame,
// together with the character and its parity/stop error flags.
module rx_serial_7O1
    import rx_trena_mensagem_pkg::*;
#(
    parameter int M_BIT = 434,
    parameter int N_BIT = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       entrada_serial,
    output logic [6:0] caractere,
    output logic       char_pronto,
    output logic       err_par,
    output logic       err_stop
);

    localparam logic [N_BIT-1:0] FIM_MEIO = N_BIT'(M_BIT / 2 - 1);
    localparam logic [N_BIT-1:0] FIM_BIT  = N_BIT'(M_BIT - 1);

    rx_estado_t       estado, proximo;
    logic             sync1, sync2;
    logic [N_BIT-1:0] conta;
    logic [2:0]       indice;
    logic [6:0]       dados;
    logic             bit_par;
    logic             amostra;

    // Next-state logic; amostra marks the cycle in which the line is sampled.
    always_comb begin
        proximo = estado;
        amostra = 1'b0;
        case (estado)
            REPOUSO:  if (!sync2) proximo = INICIO;
            INICIO:   if (conta == FIM_MEIO) begin
                          amostra = 1'b1;
                          // Line back high at mid start bit: a glitch, not a frame.
                          proximo = sync2 ? REPOUSO : DADOS;
                      end
            DADOS:    if (conta == FIM_BIT) begin
                          amostra = 1'b1;
                          if (indice == 3'd6) proximo = PARIDADE;
                      end
            PARIDADE: if (conta == FIM_BIT) begin
                          amostra = 1'b1;
                          proximo = PARADA;
                      end
            PARADA:   if (conta == FIM_BIT) begin
                          amostra = 1'b1;
                          // Leave at mid stop bit so a back-to-back start edge is seen.
                          proximo = REPOUSO;
                      end
            default:  proximo = REPOUSO;
        endcase
    end

    // Rx state register.
    always_ff @(posedge clock) begin
        if (reset) estado <= REPOUSO;
        else       estado <= proximo;
    end

    // Synchroniser, bit counter, data shift register and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            conta       <= '0;
            indice      <= '0;
            dados       <= '0;
            bit_par     <= 1'b0;
            caractere   <= '0;
            char_pronto <= 1'b0;
            err_par     <= 1'b0;
            err_stop    <= 1'b0;
        end else begin
            sync1       <= entrada_serial;
            sync2       <= sync1;
            char_pronto <= 1'b0;
            if (estado == REPOUSO || amostra) conta <= '0;
            else                              conta <= conta + N_BIT'(1);
            if (estado == INICIO) indice <= '0;
            if (amostra) begin
                case (estado)
                    DADOS: begin
                        // LSB arrives first, so shift in from the top.
                        dados  <= {sync2, dados[6:1]};
                        indice <= indice + 3'd1;
                    end
                    PARIDADE: bit_par <= sync2;
                    PARADA: begin
                        caractere   <= dados;
                        char_pronto <= 1'b1;
                        // Odd parity: data plus parity must hold an odd count of ones.
                        err_par     <= ~(^{dados, bit_par});
                        err_stop    <= ~sync2;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/rx_trena_mensagem.sv
// Trena message receiver: parses "A2A1A0,D2D1D0#" from the 7O1 character
// stream and publishes both BCD triplets atomically with a pronto pulse.
module rx_trena_mensagem
    import rx_trena_mensagem_pkg::*;
#(
    parameter int M_BIT = 434,
    parameter int N_BIT = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       entrada_serial,
    output logic [3:0] angulo_centena,
    output logic [3:0] angulo_dezena,
    output logic [3:0] angulo_unidade,
    output logic [3:0] distancia_centena,
    output logic [3:0] distancia_dezena,
    output logic [3:0] distancia_unidade,
    output logic       pronto,
    output logic       erro,
    output logic [1:0] erro_cod,
    output logic [3:0] db_estado
);

    logic [6:0] caractere;
    logic       char_pronto, err_par, err_stop;

    rx_serial_7O1 #(.M_BIT(M_BIT), .N_BIT(N_BIT)) u_rx (
        .clock          (clock),
        .reset          (reset),
        .entrada_serial (entrada_serial),
        .caractere      (caractere),
        .char_pronto    (char_pronto),
        .err_par        (err_par),
        .err_stop       (err_stop)
    );

    parser_estado_t  estado, proximo;
    logic [5:0][3:0] sombra;   // digits of the message being received
    logic [5:0][3:0] saida;    // digits of the last accepted message
    logic            grava, publica, sinaliza;
    logic [2:0]      idx;
    logic [1:0]      cod_n;
    logic            aceito;

    // Parser next-state: error priority stop > parity > unexpected character.
    always_comb begin
        proximo  = estado;
        grava    = 1'b0;
        publica  = 1'b0;
        sinaliza = 1'b0;
        cod_n    = erro_cod;
        aceito   = 1'b0;
        idx      = 3'd0;
        case (estado)
            ESPERA_A1: idx = 3'd1;
            ESPERA_A0: idx = 3'd2;
            ESPERA_D2: idx = 3'd3;
            ESPERA_D1: idx = 3'd4;
            ESPERA_D0: idx = 3'd5;
            default:   idx = 3'd0;
        endcase
        case (estado)
            ESPERA_VIRG: aceito = (caractere == ASCII_VIRGULA);
            ESPERA_FIM:  aceito = (caractere == ASCII_FIM);
            default:     aceito = eh_digito(caractere);
        endcase
        if (char_pronto) begin
            if (estado == DESCARTE) begin
                // Only a clean '#' resynchronises; nothing else is reported.
                if (caractere == ASCII_FIM && !err_par && !err_stop)
                    proximo = ESPERA_A2;
            end else if (err_stop) begin
                sinaliza = 1'b1;
                cod_n    = ERR_PARADA;
                proximo  = DESCARTE;
            end else if (err_par) begin
                sinaliza = 1'b1;
                cod_n    = ERR_PARIDADE;
                proximo  = DESCARTE;
            end else if (aceito) begin
                if (estado == ESPERA_FIM) begin
                    publica = 1'b1;
                    cod_n   = ERR_NENHUM;
                    proximo = ESPERA_A2;
                end else begin
                    grava   = (estado != ESPERA_VIRG);
                    proximo = parser_estado_t'(estado + 4'd1);
                end
            end else begin
                sinaliza = 1'b1;
                cod_n    = ERR_CARACTERE;
                // A stray '#' already marks a message boundary.
                proximo  = (caractere == ASCII_FIM) ? ESPERA_A2 : DESCARTE;
            end
        end
    end

    // Parser state register.
    always_ff @(posedge clock) begin
        if (reset) estado <= ESPERA_A2;
        else       estado <= proximo;
    end

    // Shadow digits, published outputs and the pronto/erro pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            sombra   <= '0;
            saida    <= '0;
            pronto   <= 1'b0;
            erro     <= 1'b0;
            erro_cod <= ERR_NENHUM;
        end else begin
            pronto   <= publica;
            erro     <= sinaliza;
            erro_cod <= cod_n;
            if (grava)   sombra[idx] <= caractere[3:0];
            if (publica) saida       <= sombra;
        end
    end

    assign angulo_centena    = saida[0];
    assign angulo_dezena     = saida[1];
    assign angulo_unidade    = saida[2];
    assign distancia_centena = saida[3];
    assign distancia_dezena  = saida[4];
    assign distancia_unidade = saida[5];
    assign db_estado         = estado;

endmodule

// File: doc/rx_trena_mensagem.md
Name: rx_trena_mensagem

Overview:
Receiver end of the trena serial link. It deserialises 7O1 asynchronous characters (1 start bit, 7 data bits LSB-first, odd parity, 1 stop bit) and parses the fixed 8-character message A2 A1 A0 ',' D2 D1 D0 '#'. A2..A0 are the angle digits and D2..D0 the distance digits, all ASCII '0'..'9'. It presents both 3-digit BCD values atomically with a ready pulse, and sits on the host/test-board side of the link.

Parameters:
M_BIT, 434, clocks per bit period (50 MHz / 115200 baud); must be >= 4.
N_BIT, 9, width of the bit-period counter (must hold M_BIT-1).

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
entrada_serial  input  1  serial line, idles high, asynchronous to clock
angulo_centena  output  4  BCD angle hundreds
angulo_dezena  output  4  BCD angle tens
angulo_unidade  output  4  BCD angle units
distancia_centena  output  4  BCD distance hundreds
distancia_dezena  output  4  BCD distance tens
distancia_unidade  output  4  BCD distance units
pronto  output  1  one-cycle pulse: new valid message latched
erro  output  1  one-cycle pulse: message rejected
erro_cod  output  2  last error cause (hold): 00 none, 01 parity, 10 invalid char, 11 stop bit
db_estado  output  4  parser state, debug only

Behaviour:
- Interface fixed as decided: one clock, port named clock; reset is synchronous and active-high, port named reset.
- Reset values: all digit outputs 0, pronto 0, erro 0, erro_cod 00, parser in ESPERA_A2, rx in REPOUSO. Reset takes effect mid-frame or mid-message: the partial message is discarded.
- Input sync: entrada_serial passes through 2 flops (both reset to 1) before any use.
- Rx FSM states: REPOUSO, INICIO, DADOS, PARIDADE, PARADA.
  - REPOUSO -> INICIO on synchronised line = 0.
  - INICIO: wait M_BIT/2 clocks, then resample. If the line is 1 (glitch), return to REPOUSO with no output. Otherwise go to DADOS.
  - DADOS: sample every M_BIT clocks, 7 bits, LSB first.
  - PARIDADE: sample the parity bit. It is valid if the number of ones in data plus parity is odd.
  - PARADA: sample the stop bit, then raise char_pronto for 1 cycle with char[6:0], err_par and err_stop. Return immediately to REPOUSO, so a back-to-back start bit right after stop is accepted.
- Parser FSM states: ESPERA_A2, ESPERA_A1, ESPERA_A0, ESPERA_VIRG, ESPERA_D2, ESPERA_D1, ESPERA_D0, ESPERA_FIM, DESCARTE. It advances only on char_pronto.
- Digit states accept 0x30..0x39 and store the low nibble in shadow registers. ESPERA_VIRG accepts only 0x2C; ESPERA_FIM accepts only 0x23.
- Valid '#' in ESPERA_FIM: copy the shadow registers to all six outputs in the same cycle, pulse pronto 1 cycle later than char_pronto, set erro_cod 00, go to ESPERA_A2.
- Error priority, checked on any char_pronto: stop error (11) > parity error (01) > unexpected char (10).
  - On error: pulse erro 1 cycle, update erro_cod, leave outputs unchanged, go to DESCARTE.
  - Exception: an unexpected '#' with no parity/stop error pulses erro (10) and goes directly to ESPERA_A2.
- DESCARTE: ignore characters until a '#' with no parity/stop error, then go to ESPERA_A2 with no pronto. A bad character in DESCARTE raises no additional erro.
- pronto and erro are never high in the same cycle.
- Latency: pronto rises 1 clock after char_pronto for '#'. char_pronto occurs M_BIT/2 + 9*M_BIT (+2 sync) clocks after the start-bit falling edge.

Decomposition:
- Shared constants file/package holds:
  - ASCII constants: ASCII_0 = 0x30, ASCII_9 = 0x39, ASCII_VIRGULA = 0x2C, ASCII_FIM = 0x23.
  - Error codes.
  - Rx and parser state encodings.
- One sub-module: rx_serial_7O1 (sync flops, bit counter, rx FSM; outputs char, char_pronto, err_par, err_stop).
- The parser and output registers live in rx_trena_mensagem.

Test Plan:
- Reset, then "090,123#" at M_BIT -> angulo = 0/9/0, distancia = 1/2/3; pronto exactly 1 pulse; erro never high.
- Valid message, then "045,678#" with bad parity on '4' -> erro pulse with erro_cod = 01; outputs hold 0/9/0, 1/2/3. A following "180,200#" gives pronto, outputs 1/8/0, 2/0/0, and erro_cod = 00.
- "0A0,123#" -> erro with code 10 on 'A', remainder discarded, no pronto; the next "010,005#" is accepted.
- Stop bit forced to 0 on ',' -> erro with code 11; "12#" alone (unexpected '#') -> erro with code 10 and immediate resync; the next full message is accepted.
- Low glitch of M_BIT/4 clocks on the idle line -> no char_pronto, no erro; a valid message immediately after is decoded.
- Back-to-back messages with zero idle gap, plus reset asserted mid-D1 -> outputs 0 after reset, partial message dropped, the subsequent "359,999#" decodes to 3/5/9, 9/9/9.
